// File: rtl/perf_event_collector.sv
// rtl/perf_event_collector.sv - registers core event strobes and runs the run/drain/done enable FSM
// Optional: define PERF_EBREAK_HALT_EN to also end the program on a retiring EBREAK.
module perf_event_collector #(
    parameter int unsigned HALT_WINDOW = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] if_instr,
    input  logic        if_stall,
    input  logic        id_bubble,
    input  logic        ex_flush,
    input  logic        load_use_hazard,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        wb_valid,
    input  logic [31:0] wb_instr,
    output logic        perf_enable,
    output logic        instruction_retired,
    output logic        pipeline_stall,
    output logic        pipeline_bubble,
    output logic        pipeline_flush,
    output logic        raw_hazard_detected,
    output logic        forward_ex_to_ex,
    output logic        forward_mem_to_ex,
    output logic        conditional_branch,
    output logic        unconditional_branch,
    output logic        program_done
);

    localparam int unsigned CW = $clog2(HALT_WINDOW + 1);
    localparam logic [CW-1:0] ZCNT_LAST = CW'(HALT_WINDOW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] zcnt_q;
    logic [CW-1:0] zcnt_d;
    logic [8:0]    events_q;
    logic [8:0]    events_d;
    logic          perf_enable_q;
    logic          program_done_q;
    logic          zero_word;
    logic          zero_halt;
    logic          ebreak_halt;

    assign events_d = {
        wb_valid,
        if_stall,
        id_bubble,
        ex_flush,
        load_use_hazard,
        (fwd_a_sel == 2'b01) | (fwd_b_sel == 2'b01),
        (fwd_a_sel == 2'b10) | (fwd_b_sel == 2'b10),
        ex_valid & ex_is_branch,
        ex_valid & ex_is_jump & ~ex_is_branch
    };

    // Stalled cycles neither extend nor break the zero window.
    assign zero_word = (if_instr == 32'h0);
    assign zero_halt = ~if_stall & zero_word & (zcnt_q == ZCNT_LAST);
    assign zcnt_d    = if_stall ? zcnt_q : (zero_word ? zcnt_q + CW'(1) : '0);

`ifdef PERF_EBREAK_HALT_EN
    assign ebreak_halt = wb_valid & (wb_instr == 32'h0010_0073);
`else
    logic unused_wb_instr;
    assign unused_wb_instr = ^wb_instr;
    assign ebreak_halt     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            zcnt_q         <= '0;
            events_q       <= '0;
            perf_enable_q  <= 1'b0;
            program_done_q <= 1'b0;
        end else begin
            events_q <= (state_q == S_RUN) ? events_d : '0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q       <= S_RUN;
                        perf_enable_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (ebreak_halt || zero_halt) begin
                        state_q <= S_DRAIN;
                        zcnt_q  <= '0;
                    end else begin
                        zcnt_q <= zcnt_d;
                    end
                end
                S_DRAIN: begin
                    state_q        <= S_DONE;
                    perf_enable_q  <= 1'b0;
                    program_done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign perf_enable          = perf_enable_q;
    assign program_done         = program_done_q;
    assign instruction_retired  = events_q[8];
    assign pipeline_stall       = events_q[7];
    assign pipeline_bubble      = events_q[6];
    assign pipeline_flush       = events_q[5];
    assign raw_hazard_detected  = events_q[4];
    assign forward_ex_to_ex     = events_q[3];
    assign forward_mem_to_ex    = events_q[2];
    assign conditional_branch   = events_q[1];
    assign unconditional_branch = events_q[0];

endmodule

// File: tb/tb_perf_event_collector.sv
// tb/tb_perf_event_collector.sv - scoreboard bench for perf_event_collector
module tb_perf_event_collector;

    localparam int HW = 10;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst_n;
    logic start, if_stall, id_bubble, ex_flush, load_use_hazard;
    logic ex_valid, ex_is_branch, ex_is_jump, wb_valid;
    logic [31:0] if_instr, wb_instr;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic perf_enable, instruction_retired, pipeline_stall, pipeline_bubble, pipeline_flush;
    logic raw_hazard_detected, forward_ex_to_ex, forward_mem_to_ex;
    logic conditional_branch, unconditional_branch, program_done;

    always #5 clk = ~clk;

    perf_event_collector #(.HALT_WINDOW(HW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .if_instr(if_instr), .if_stall(if_stall),
        .id_bubble(id_bubble), .ex_flush(ex_flush), .load_use_hazard(load_use_hazard),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .wb_valid(wb_valid),
        .wb_instr(wb_instr), .perf_enable(perf_enable),
        .instruction_retired(instruction_retired), .pipeline_stall(pipeline_stall),
        .pipeline_bubble(pipeline_bubble), .pipeline_flush(pipeline_flush),
        .raw_hazard_detected(raw_hazard_detected), .forward_ex_to_ex(forward_ex_to_ex),
        .forward_mem_to_ex(forward_mem_to_ex), .conditional_branch(conditional_branch),
        .unconditional_branch(unconditional_branch), .program_done(program_done)
    );

    typedef logic [10:0] vec_t;
    vec_t expq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   halts = 0;

    // Reference: phase 0 idle, 1 run, 2 drain, 3 done; zrun = qualifying zeros in a row.
    int m_phase = 0;
    int m_zrun = 0;

    function automatic vec_t outs_now();
        return {perf_enable, program_done, instruction_retired, pipeline_stall,
                pipeline_bubble, pipeline_flush, raw_hazard_detected, forward_ex_to_ex,
                forward_mem_to_ex, conditional_branch, unconditional_branch};
    endfunction

    task automatic model_cycle(output vec_t e);
        logic [8:0] ev;
        bit halt;
        ev = '0;
        if (m_phase == 1)
            ev = {wb_valid, if_stall, id_bubble, ex_flush, load_use_hazard,
                  (fwd_a_sel == 2'd1) || (fwd_b_sel == 2'd1),
                  (fwd_a_sel == 2'd2) || (fwd_b_sel == 2'd2),
                  ex_valid && ex_is_branch,
                  ex_valid && ex_is_jump && !ex_is_branch};
        case (m_phase)
            0: if (start) m_phase = 1;
            1: begin
                halt = 1'b0;
`ifdef PERF_EBREAK_HALT_EN
                if (wb_valid && wb_instr == EBREAK) halt = 1'b1;
`endif
                if (!halt && !if_stall) begin
                    m_zrun = (if_instr == 32'd0) ? m_zrun + 1 : 0;
                    if (m_zrun == HW) halt = 1'b1;
                end
                if (halt) begin
                    m_phase = 2;
                    m_zrun = 0;
                    halts++;
                end
            end
            2: m_phase = 3;
            default: ;
        endcase
        e = {(m_phase == 1) || (m_phase == 2), m_phase == 3, ev};
    endtask

    always @(negedge clk) begin
        vec_t e;
        cyc++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (outs_now() !== e) begin
                failures++;
                $display("FAIL outputs cyc=%0d got=%b exp=%b (pe,done,ret,stall,bub,flush,raw,fex,fmem,cbr,ubr)",
                         cyc, outs_now(), e);
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // mode 0: normal, 1: async reset pulse before the edge, 2: reset held across the edge
    task automatic commit(input int mode);
        vec_t e;
        if (mode == 2) begin
            rst_n = 1'b0;
            m_phase = 0;
            m_zrun = 0;
            expq.push_back('0);
            return;
        end
        if (mode == 1) begin
            rst_n = 1'b0;
            #2;
            checks++;
            if (outs_now() !== '0) begin
                failures++;
                $display("FAIL async_reset got=%b exp=0", outs_now());
            end
            m_phase = 0;
            m_zrun = 0;
        end
        rst_n = 1'b1;
        model_cycle(e);
        expq.push_back(e);
    endtask

    task automatic quiet();
        start = 0; if_instr = 32'h13; if_stall = 0; id_bubble = 0; ex_flush = 0;
        load_use_hazard = 0; fwd_a_sel = 0; fwd_b_sel = 0; ex_valid = 0;
        ex_is_branch = 0; ex_is_jump = 0; wb_valid = 0; wb_instr = 0;
    endtask

    task automatic rand_inputs(input int zero_pct);
        start = ($urandom % 4) == 0;
        if_instr = ($urandom_range(99) < zero_pct) ? 32'd0 : $urandom;
        if_stall = ($urandom % 5) == 0;
        id_bubble = 1'($urandom); ex_flush = 1'($urandom); load_use_hazard = 1'($urandom);
        fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
        ex_valid = 1'($urandom); ex_is_branch = 1'($urandom); ex_is_jump = 1'($urandom);
        wb_valid = 1'($urandom);
        wb_instr = ($urandom % 16 == 0) ? EBREAK : $urandom;
    endtask

    task automatic restart();
        next_cycle(); quiet(); start = 1; commit(1);
        next_cycle(); quiet(); commit(0);
    endtask

    initial begin
        int zp;
        rst_n = 1'b0;
        quiet();
        for (int i = 0; i < 5; i++) begin next_cycle(); rand_inputs(50); commit(2); end
        for (int i = 0; i < 5; i++) begin next_cycle(); rand_inputs(50); start = 0; commit(0); end

        // start then a single retire
        next_cycle(); quiet(); start = 1; commit(0);
        next_cycle(); quiet(); wb_valid = 1; commit(0);
        next_cycle(); quiet(); commit(0);

        // forwarding kinds and branch priority
        next_cycle(); quiet(); fwd_a_sel = 2'b01; fwd_b_sel = 2'b10; commit(0);
        next_cycle(); quiet(); fwd_a_sel = 2'b11; fwd_b_sel = 2'b11; commit(0);
        next_cycle(); quiet(); ex_valid = 1; ex_is_branch = 1; ex_is_jump = 1; commit(0);
        next_cycle(); quiet(); if_stall = 1; id_bubble = 1; commit(0);

        // plain zero window, flush on the RUN->DRAIN edge and during DRAIN
        for (int i = 0; i < HW + 4; i++) begin
            next_cycle(); quiet(); if_instr = 0;
            if (i >= HW - 1) ex_flush = 1;
            commit(0);
        end

        // nonzero word at zero #9 restarts the window
        restart();
        for (int i = 0; i < 2 * HW + 3; i++) begin
            next_cycle(); quiet(); if_instr = (i == 8) ? 32'h13 : 32'd0; commit(0);
        end

        // three stalled cycles inside the window delay the halt
        restart();
        for (int i = 0; i < HW + 6; i++) begin
            next_cycle(); quiet(); if_instr = 0; if_stall = (i >= 3 && i < 6); commit(0);
        end

        // EBREAK retire (halts only when the feature is built in)
        restart();
        next_cycle(); quiet(); wb_valid = 1; wb_instr = EBREAK; commit(0);
        for (int i = 0; i < 3; i++) begin next_cycle(); quiet(); commit(0); end

        // async reset mid-RUN, then idle until start returns
        restart();
        next_cycle(); quiet(); wb_valid = 1; commit(0);
        next_cycle(); quiet(); wb_valid = 1; commit(1);
        for (int i = 0; i < 3; i++) begin next_cycle(); quiet(); wb_valid = 1; commit(0); end

        zp = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 100 == 0) zp = (i % 300 == 0) ? 95 : ((i % 200 == 0) ? 30 : 70);
            next_cycle();
            rand_inputs(zp);
            commit(($urandom % 150 == 0) ? 1 : 0);
        end

        next_cycle();
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", expq.size());
        end
        checks++;
        if (halts < 3) begin
            failures++;
            $display("FAIL halt_coverage got=%0d exp>=3", halts);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
